// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video pattern blocks:
//   - pattern mode encodings (3-bit mode input of pattern_gen)
//   - the eight colour-bar colours plus the extra colours used by the patterns
//   - bounce direction encoding used by bounce_axis
//   - bar_colour(): maps a bar index 0..7 to its colour
// ---------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [2:0] {
        MODE_BOX    = 3'd0,
        MODE_BARS   = 3'd1,
        MODE_GRAD   = 3'd2,
        MODE_CHK    = 3'd3,
        MODE_BOUNCE = 3'd4
    } mode_e;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    // Colour-bar colours, left to right.
    localparam logic [23:0] COL_WHITE   = 24'hffffff;
    localparam logic [23:0] COL_YELLOW  = 24'hffff00;
    localparam logic [23:0] COL_CYAN    = 24'h00ffff;
    localparam logic [23:0] COL_GREEN   = 24'h00ff00;
    localparam logic [23:0] COL_MAGENTA = 24'hff00ff;
    localparam logic [23:0] COL_RED     = 24'hff0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000ff;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Background of the bouncing-box pattern.
    localparam logic [23:0] COL_GREY    = 24'h202020;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// ---------------------------------------------------------------------------
// bounce_axis
// Position/direction of the bouncing box along one axis. On every tick the
// position moves STEP pixels in the current direction and reverses at the
// edges 0 and LIM-SIZE, clamping onto the edge it hit.
//
// Ports:
//   clk   in   pixel clock
//   rst   in   asynchronous active-low reset (pos=0, direction positive)
//   tick  in   frame-start strobe, one update per pulse
//   pos   out  WB+2 bit position of the box's leading edge
// ---------------------------------------------------------------------------
module bounce_axis
    import video_pkg::*;
#(
    parameter int LIM  = 640,
    parameter int SIZE = 64,
    parameter int STEP = 2,
    parameter int WB   = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    output logic [WB+1:0] pos
);

    // One bit wider than the coordinates so pos+STEP cannot wrap.
    typedef logic [WB+1:0] pos_t;

    localparam pos_t P_MAX  = pos_t'(LIM - SIZE);
    localparam pos_t P_STEP = pos_t'(STEP);

    dir_e dir;
    pos_t nxt_up;

    assign nxt_up = pos + P_STEP;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
            dir <= DIR_POS;
        end else if (tick) begin
            if (dir == DIR_POS) begin
                if (nxt_up >= P_MAX) begin
                    pos <= P_MAX;
                    dir <= DIR_NEG;
                end else begin
                    pos <= nxt_up;
                end
            end else begin
                if (pos <= P_STEP) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - P_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// ---------------------------------------------------------------------------
// pattern_gen
// Test-pattern generator driven by an external timing generator's pixel
// coordinates. The pattern is selected per frame (mode sampled at sx=sy=0)
// and the colour is registered, so rgb lags sx/sy by exactly one cycle.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous active-low reset
//   sx, sy     in   current pixel coordinates (WB+1 bits)
//   mode       in   requested pattern: 0 box, 1 bars, 2 gradient,
//                   3 checker, 4 bouncing box, 5-7 black
//   rgb        out  registered {R,G,B}
//   frame_cnt  out  frame starts since reset, wraps at 256
// ---------------------------------------------------------------------------
module pattern_gen
    import video_pkg::*;
#(
    parameter int WB     = 9,
    parameter int SW     = 640,
    parameter int SH     = 480,
    parameter int MARGIN = 100,
    parameter int BOX    = 64,
    parameter int STEP   = 2,
    parameter int CHK    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [WB:0] sx,
    input  logic [WB:0] sy,
    input  logic [2:0]  mode,
    output logic [23:0] rgb,
    output logic [7:0]  frame_cnt
);

    typedef logic [WB:0]   coord_t;
    typedef logic [WB+1:0] pos_t;

    // Comparisons are done one bit wider than the coordinates so constants
    // such as SW cannot alias onto a valid pixel.
    localparam pos_t X_END   = pos_t'(SW);
    localparam pos_t Y_END   = pos_t'(SH);
    localparam pos_t X_LAST  = pos_t'(SW - 1);
    localparam pos_t Y_LAST  = pos_t'(SH - 1);
    localparam pos_t IN_X0   = pos_t'(MARGIN);
    localparam pos_t IN_X1   = pos_t'(SW - MARGIN);
    localparam pos_t IN_Y0   = pos_t'(MARGIN);
    localparam pos_t IN_Y1   = pos_t'(SH - MARGIN);
    localparam pos_t BOX_W   = pos_t'(BOX);

    // Colour bars: SW/8 pixels each; index 8 marks the leftover right edge.
    localparam coord_t     BAR_LAST = coord_t'(SW / 8 - 1);
    localparam logic [3:0] BAR_DONE = 4'd8;

    logic       frame_start;
    logic [2:0] mode_q;
    // Cleared by reset, set by the first frame start: a frame interrupted by
    // reset stays black instead of resuming mid-picture.
    logic       frame_ok;

    logic [3:0] bar_idx_q, bar_idx_cur, bar_idx_nxt;
    coord_t     bar_run_q, bar_run_cur, bar_run_nxt;

    pos_t        bx, by, xe, ye;
    logic        blank, border, inner, in_box;
    logic [23:0] rgb_d;

    assign frame_start = (sx == '0) && (sy == '0);

    assign xe = pos_t'(sx);
    assign ye = pos_t'(sy);

    bounce_axis #(.LIM(SW), .SIZE(BOX), .STEP(STEP), .WB(WB)) u_bx (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_start),
        .pos  (bx)
    );

    bounce_axis #(.LIM(SH), .SIZE(BOX), .STEP(STEP), .WB(WB)) u_by (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_start),
        .pos  (by)
    );

    // Run counter for the bar index: restarts at sx==0 and steps once every
    // SW/8 pixels, relying on sx advancing by one per clock within a line.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        bar_idx_cur = bar_idx_q;
        bar_run_cur = bar_run_q;
        if (sx == '0) begin
            bar_idx_cur = '0;
            bar_run_cur = '0;
        end
        bar_idx_nxt = bar_idx_cur;
        bar_run_nxt = bar_run_cur + coord_t'(1);
        if (bar_run_cur == BAR_LAST) begin
            bar_run_nxt = '0;
            if (bar_idx_cur != BAR_DONE)
                bar_idx_nxt = bar_idx_cur + 4'd1;
        end
    end

    assign blank  = (xe >= X_END) || (ye >= Y_END);
    assign border = (xe == '0) || (xe >= X_LAST) || (ye == '0) || (ye >= Y_LAST);
    assign inner  = (xe >= IN_X0) && (xe < IN_X1) && (ye >= IN_Y0) && (ye < IN_Y1);
    assign in_box = (xe >= bx) && (xe < bx + BOX_W) && (ye >= by) && (ye < by + BOX_W);

    always_comb begin
        rgb_d = COL_BLACK;
        if (frame_ok && !blank) begin
            case (mode_q)
                MODE_BOX:    rgb_d = (border || inner) ? COL_WHITE : COL_BLUE;
                MODE_BARS:   rgb_d = (bar_idx_cur < BAR_DONE) ? bar_colour(bar_idx_cur[2:0])
                                                              : COL_BLACK;
                MODE_GRAD:   rgb_d = {sy[7:0], sx[7:0], frame_cnt};
                MODE_CHK:    rgb_d = (sx[CHK] ^ sy[CHK] ^ frame_cnt[5]) ? COL_WHITE
                                                                        : COL_BLACK;
                MODE_BOUNCE: rgb_d = in_box ? COL_RED : COL_GREY;
                default:     rgb_d = COL_BLACK;
            endcase
        end
    end

    // At frame start rgb_d still uses the old mode_q/frame_cnt/box position;
    // the newly latched values apply from the following pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb       <= '0;
            frame_cnt <= '0;
            mode_q    <= '0;
            frame_ok  <= 1'b0;
            bar_idx_q <= '0;
            bar_run_q <= '0;
        end else begin
            rgb       <= rgb_d;
            bar_idx_q <= bar_idx_nxt;
            bar_run_q <= bar_run_nxt;
            if (frame_start) begin
                mode_q    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
                frame_ok  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_pattern_gen
// Directed bench for pattern_gen with default parameters (640x480, box 64,
// step 2, checker 32). Inputs change on the falling edge; outputs are checked
// 1 time unit after the rising edge that registers them.
// ---------------------------------------------------------------------------
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  sx, sy;
    logic [2:0]  mode;
    logic [23:0] rgb;
    logic [7:0]  frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int nfs     = 0;   // frame starts driven since the last reset

    pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .sx        (sx),
        .sy        (sy),
        .mode      (mode),
        .rgb       (rgb),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        n_tests++;
        assert (rgb === exp) else begin
            n_fail++;
            $error("FAIL %s: rgb=%06h expected %06h", tag, rgb, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] exp);
        n_tests++;
        assert (frame_cnt === exp) else begin
            n_fail++;
            $error("FAIL %s: frame_cnt=%0d expected %0d", tag, frame_cnt, exp);
        end
    endtask

    // Present one pixel; on return rgb holds the colour for that pixel.
    task automatic drive(input int x, input int y);
        @(negedge clk);
        sx = 10'(x);
        sy = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic fs();
        drive(0, 0);
        nfs++;
    endtask

    task automatic advance_to(input int n);
        while (nfs < n) begin
            fs();
            drive(7, 7);
        end
    endtask

    initial begin
        rst  = 1'b0;
        sx   = 10'd5;
        sy   = 10'd5;
        mode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_rgb("reset_rgb", 24'h000000);
        check_cnt("reset_cnt", 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Mode 0. The first frame start after reset still outputs black.
        fs();
        check_rgb("first_fs_black", 24'h000000);
        check_cnt("first_fs_cnt", 8'd1);
        drive(50, 50);   check_rgb("box_50_50", 24'h0000ff);
        drive(100, 100); check_rgb("box_100_100", 24'hffffff);
        drive(539, 379); check_rgb("box_539_379", 24'hffffff);
        drive(540, 380); check_rgb("box_540_380", 24'h0000ff);
        drive(639, 479); check_rgb("box_639_479", 24'hffffff);
        drive(320, 0);   check_rgb("box_top_edge", 24'hffffff);
        drive(640, 10);  check_rgb("blank_x", 24'h000000);
        drive(10, 480);  check_rgb("blank_y", 24'h000000);
        fs();
        check_rgb("box_0_0", 24'hffffff);
        check_cnt("cnt_2", 8'd2);

        // Mode 1: one full line of colour bars.
        mode = 3'd1;
        fs();
        for (int x = 0; x < 640; x++) begin
            drive(x, 10);
            case (x)
                0, 79:    check_rgb("bar_white", 24'hffffff);
                80:       check_rgb("bar_yellow", 24'hffff00);
                160:      check_rgb("bar_cyan", 24'h00ffff);
                479:      check_rgb("bar_red", 24'hff0000);
                480:      check_rgb("bar_blue", 24'h0000ff);
                560, 639: check_rgb("bar_black", 24'h000000);
                default:  ;
            endcase
        end

        // Mode change mid-frame only takes effect at the next frame start.
        mode = 3'd0;
        advance_to(6);
        drive(50, 50);   check_rgb("pre_change", 24'h0000ff);
        mode = 3'd2;
        drive(50, 50);   check_rgb("mid_frame_hold", 24'h0000ff);
        fs();
        check_rgb("fs_old_mode", 24'hffffff);
        check_cnt("cnt_7", 8'd7);
        drive(3, 5);     check_rgb("grad_3_5", 24'h050307);
        drive(700, 5);   check_rgb("grad_blank", 24'h000000);

        // Unused mode.
        mode = 3'd5;
        fs();
        drive(100, 100); check_rgb("mode5_black", 24'h000000);

        // Checker, phase from frame_cnt bit 5.
        mode = 3'd3;
        fs();
        drive(1, 1);     check_rgb("chk9_1_1", 24'h000000);
        drive(32, 1);    check_rgb("chk9_32_1", 24'hffffff);
        drive(33, 33);   check_rgb("chk9_33_33", 24'h000000);
        advance_to(31);
        drive(1, 1);     check_rgb("chk31_1_1", 24'h000000);
        fs();
        drive(1, 1);     check_rgb("chk32_1_1", 24'hffffff);
        drive(32, 1);    check_rgb("chk32_32_1", 24'h000000);
        advance_to(63);
        drive(1, 1);     check_rgb("chk63_1_1", 24'hffffff);
        fs();
        drive(1, 1);     check_rgb("chk64_1_1", 24'h000000);

        // Bouncing box; frame counter wrap on the way.
        mode = 3'd4;
        advance_to(255);
        check_cnt("cnt_255", 8'd255);
        fs();
        check_cnt("cnt_wrap", 8'd0);
        advance_to(288);
        check_cnt("cnt_288", 8'd32);
        // bx=576 (just reversed), by=256 (on the way back up from 416)
        drive(576, 256); check_rgb("bb288_in", 24'hff0000);
        drive(575, 256); check_rgb("bb288_left", 24'h202020);
        drive(639, 319); check_rgb("bb288_corner", 24'hff0000);
        drive(576, 320); check_rgb("bb288_below", 24'h202020);
        drive(576, 255); check_rgb("bb288_above", 24'h202020);
        fs();
        check_cnt("cnt_289", 8'd33);
        // bx=574, by=254
        drive(574, 254); check_rgb("bb289_in", 24'hff0000);
        drive(573, 254); check_rgb("bb289_left", 24'h202020);
        drive(637, 254); check_rgb("bb289_right_in", 24'hff0000);
        drive(638, 254); check_rgb("bb289_right_out", 24'h202020);

        // Asynchronous reset in the middle of a frame.
        drive(320, 240); check_rgb("pre_reset", 24'h202020);
        #2;
        rst = 1'b0;
        #1;
        check_rgb("async_rst_rgb", 24'h000000);
        check_cnt("async_rst_cnt", 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        nfs = 0;
        drive(320, 240); check_rgb("abandoned_frame", 24'h000000);
        drive(321, 240); check_rgb("abandoned_frame2", 24'h000000);
        mode = 3'd2;
        fs();
        check_rgb("post_rst_fs", 24'h000000);
        check_cnt("post_rst_cnt", 8'd1);
        drive(3, 5);     check_rgb("post_rst_grad", 24'h050301);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
